// File: rtl/regfile_servo_bank.sv
// Register file with two combinational read ports, one write port with bypass, and a hardwired-zero r0.
// Reads take 0 cycles. Writes land at the edge. A commit reaches servo_out one edge later.
// No backpressure: every write and every commit is accepted in the cycle it is presented.
module regfile_servo_bank #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SERVO  = 6,
  parameter int SERVO_BASE = 1,
  parameter int SERVO_W    = 7,
  parameter int SERVO_MAX  = 127,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                         clock,
  input  logic                         ctrl_reset,
  input  logic                         ctrl_writeEnable,
  input  logic [AW-1:0]                ctrl_writeReg,
  input  logic [DATA_W-1:0]            data_writeReg,
  input  logic [AW-1:0]                ctrl_readRegA,
  input  logic [AW-1:0]                ctrl_readRegB,
  output logic [DATA_W-1:0]            data_readRegA,
  output logic [DATA_W-1:0]            data_readRegB,
  input  logic                         servo_commit,
  output logic [NUM_SERVO*SERVO_W-1:0] servo_out,
  output logic [NUM_SERVO-1:0]         servo_dirty,
  output logic                         servo_update
);

  localparam logic [SERVO_W-1:0] CLAMP = SERVO_W'(SERVO_MAX);

  logic [DATA_W-1:0]            regs_q [NUM_REGS];
  logic [DATA_W-1:0]            regs_d [NUM_REGS];
  logic [NUM_SERVO*SERVO_W-1:0] servo_q, servo_d;
  logic [NUM_SERVO-1:0]         dirty_q, dirty_d;
  logic                         update_q, update_d;
  logic [SERVO_W-1:0]           live;
  logic                         wr_ok;

  // Writes to r0 are dropped here, so r0 never leaves its reset value.
  assign wr_ok = ctrl_writeEnable && (ctrl_writeReg != '0);

  // Next-state register array: one entry replaced by an accepted write.
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[ctrl_writeReg] = data_writeReg;
    end
  end

  // Combinational read ports; a same-cycle write to the read index is forwarded.
  always_comb begin
    data_readRegA = '0;
    data_readRegB = '0;
    if (ctrl_readRegA != '0) begin
      if (wr_ok && (ctrl_readRegA == ctrl_writeReg)) data_readRegA = data_writeReg;
      else                                           data_readRegA = regs_q[ctrl_readRegA];
    end
    if (ctrl_readRegB != '0) begin
      if (wr_ok && (ctrl_readRegB == ctrl_writeReg)) data_readRegB = data_writeReg;
      else                                           data_readRegB = regs_q[ctrl_readRegB];
    end
  end

  // Shadow bank: commit samples the pre-write live values. Dirty set is applied
  // after the commit clear, so a write that collides with a commit stays pending.
  always_comb begin
    servo_d  = servo_q;
    dirty_d  = dirty_q;
    update_d = 1'b0;
    live     = '0;
    if (servo_commit) begin
      update_d = |dirty_q;
      dirty_d  = '0;
      for (int k = 0; k < NUM_SERVO; k++) begin
        live = regs_q[SERVO_BASE + k][SERVO_W-1:0];
        servo_d[k*SERVO_W +: SERVO_W] = (live > CLAMP) ? CLAMP : live;
      end
    end
    for (int k = 0; k < NUM_SERVO; k++) begin
      if (wr_ok && (ctrl_writeReg == AW'(SERVO_BASE + k))) begin
        dirty_d[k] = 1'b1;
      end
    end
  end

  // State registers; reset wins over any same-edge write or commit.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      servo_q  <= '0;
      dirty_q  <= '0;
      update_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      servo_q  <= servo_d;
      dirty_q  <= dirty_d;
      update_q <= update_d;
    end
  end

  assign servo_out    = servo_q;
  assign servo_dirty  = dirty_q;
  assign servo_update = update_q;

endmodule

// File: tb/tb_regfile_servo_bank.sv
// Bench for regfile_servo_bank: default build plus a SERVO_MAX=100 build on shared inputs.
// Table vectors for reads/bypass, hand sequences for commit corners, random run against a model.
// Inputs change 1 time unit after the rising edge; outputs are sampled there as well.
module tb_regfile_servo_bank;

  logic        clock;
  logic        ctrl_reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic        servo_commit;
  logic [31:0] rd_a, rd_b, rd_a100, rd_b100;
  logic [41:0] so, so100;
  logic [5:0]  dirty, dirty100;
  logic        upd, upd100;

  int checks = 0;
  int errors = 0;

  regfile_servo_bank dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(rd_a), .data_readRegB(rd_b), .servo_commit(servo_commit),
    .servo_out(so), .servo_dirty(dirty), .servo_update(upd)
  );

  regfile_servo_bank #(.SERVO_MAX(100)) dut100 (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(rd_a100), .data_readRegB(rd_b100), .servo_commit(servo_commit),
    .servo_out(so100), .servo_dirty(dirty100), .servo_update(upd100)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model state
  logic [31:0] m_regs [32];
  logic [41:0] m_out, m_out100;
  logic [5:0]  m_dirty;
  logic        m_upd;

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic cm, input logic rs);
    ctrl_writeEnable = we;
    ctrl_writeReg    = wr;
    data_writeReg    = wd;
    ctrl_readRegA    = ra;
    ctrl_readRegB    = rb;
    servo_commit     = cm;
    ctrl_reset       = rs;
    #1;
  endtask

  function automatic logic [6:0] clampv(input logic [31:0] v, input int mx);
    int low;
    low = int'(v[6:0]);
    return (low > mx) ? 7'(mx) : 7'(low);
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (ctrl_writeEnable && idx == ctrl_writeReg) return data_writeReg;
    return m_regs[idx];
  endfunction

  // Advance the model by the rules for one edge, then let the DUT take the edge.
  task automatic cycle();
    if (ctrl_reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_out = '0; m_out100 = '0; m_dirty = '0; m_upd = 1'b0;
    end else begin
      m_upd = servo_commit && (m_dirty != 0);
      if (servo_commit) begin
        for (int k = 0; k < 6; k++) begin
          m_out[k*7 +: 7]    = clampv(m_regs[1+k], 127);
          m_out100[k*7 +: 7] = clampv(m_regs[1+k], 100);
        end
        m_dirty = '0;
      end
      if (ctrl_writeEnable && ctrl_writeReg != 0) begin
        m_regs[ctrl_writeReg] = data_writeReg;
        if (ctrl_writeReg >= 1 && ctrl_writeReg <= 6) m_dirty[ctrl_writeReg-1] = 1'b1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [41:0] saved;
    logic [4:0]  wr;

    vecs[0] = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0, 5'd5,  32'h0,    32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd0, 5'd5,  32'h0,    32'h0};
    vecs[2] = '{1'b1, 5'd9,  32'h1234,     5'd9, 5'd9,  32'h1234, 32'h1234};
    vecs[3] = '{1'b0, 5'd9,  32'h0,        5'd9, 5'd9,  32'h1234, 32'h1234};
    vecs[4] = '{1'b1, 5'd9,  32'h5678,     5'd9, 5'd0,  32'h5678, 32'h0};
    vecs[5] = '{1'b1, 5'd10, 32'hAA,       5'd9, 5'd10, 32'h5678, 32'hAA};
    vecs[6] = '{1'b0, 5'd10, 32'h0,        5'd10, 5'd9, 32'hAA,   32'h5678};

    // Reset for two cycles
    drive(0, 0, 0, 0, 0, 0, 1);
    @(posedge clock); #1;
    cycle();
    cycle();
    chk("rst_servo_out", so, 0);
    chk("rst_dirty", dirty, 0);
    chk("rst_update", upd, 0);

    // Table vectors: r0 discard, bypass on each port independently, persistence
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].we, vecs[i].wr, vecs[i].wd, vecs[i].ra, vecs[i].rb, 0, 0);
      chk($sformatf("vec%0d_rdA", i), rd_a, vecs[i].ea);
      chk($sformatf("vec%0d_rdB", i), rd_b, vecs[i].eb);
      cycle();
      chk($sformatf("vec%0d_dirty", i), dirty, 0);
    end
    chk("outside_window_servo_out", so, 0);

    // Commit and clamp
    drive(1, 1, 50, 0, 0, 0, 0);  cycle();
    drive(1, 2, 200, 0, 0, 0, 0); cycle();
    drive(1, 3, 32'h7F, 0, 0, 0, 0); cycle();
    chk("clamp_dirty_pre", dirty, 6'b000111);
    chk("clamp_update_pre", upd, 0);
    drive(0, 0, 0, 0, 0, 1, 0); cycle();
    chk("clamp_ch0", so[0 +: 7], 50);
    chk("clamp_ch1", so[7 +: 7], 72);
    chk("clamp_ch2_max127", so[14 +: 7], 127);
    chk("clamp_ch2_max100", so100[14 +: 7], 100);
    chk("clamp_ch1_max100", so100[7 +: 7], 72);
    chk("clamp_update", upd, 1);
    chk("clamp_dirty_post", dirty, 0);
    drive(0, 0, 0, 0, 0, 0, 0); cycle();
    chk("clamp_update_one_cycle", upd, 0);

    // Write and commit on the same edge to the same channel
    drive(1, 4, 10, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 1, 0);  cycle();
    chk("coll_ch3_first", so[21 +: 7], 10);
    drive(1, 4, 20, 4, 0, 1, 0);
    chk("coll_bypass_r4", rd_a, 20);
    cycle();
    chk("coll_ch3_old", so[21 +: 7], 10);
    chk("coll_dirty", dirty, 6'b001000);
    drive(0, 0, 0, 4, 0, 1, 0);
    chk("coll_r4_array", rd_a, 20);
    cycle();
    chk("coll_ch3_new", so[21 +: 7], 20);
    chk("coll_update", upd, 1);

    // Empty commits
    saved = so;
    drive(0, 0, 0, 0, 0, 1, 0); cycle();
    chk("empty1_update", upd, 0);
    chk("empty1_out", so, saved);
    cycle();
    chk("empty2_update", upd, 0);
    chk("empty2_out", so, saved);

    // Reset mid-operation, colliding with a commit and a write
    drive(1, 6, 33, 0, 0, 0, 0); cycle();
    chk("mid_dirty_set", dirty, 6'b100000);
    drive(1, 6, 44, 0, 0, 1, 1); cycle();
    drive(0, 0, 0, 6, 6, 0, 0);
    chk("mid_r6", rd_a, 0);
    chk("mid_ch5", so[35 +: 7], 0);
    chk("mid_servo_out", so, 0);
    chk("mid_dirty", dirty, 0);
    chk("mid_update", upd, 0);
    cycle();
    chk("mid_update_after", upd, 0);

    // Randomized run against the model
    for (int n = 0; n < 600; n++) begin
      wr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      drive($urandom_range(0, 9) < 7, wr,
            ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 255)) : $urandom,
            5'($urandom), ($urandom_range(0, 2) == 0) ? wr : 5'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 49) == 0);
      chk("rnd_rdA", rd_a, mread(ctrl_readRegA));
      chk("rnd_rdB", rd_b, mread(ctrl_readRegB));
      cycle();
      chk("rnd_servo_out", so, m_out);
      chk("rnd_servo_out100", so100, m_out100);
      chk("rnd_dirty", dirty, m_dirty);
      chk("rnd_update", upd, m_upd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
